lcm: RTL

Local configuration manager for the TSN NIC statistics path. Host-facing register block that stages a 5-tuple match rule and mask, commits them atomically to the downstream `fsm` statistics stage, generates its counter-clear pulse, and returns its packet and byte counters with a tear-free 40-bit read.

---
 rtl/lcm_pkg.sv | 62 ++++++
 rtl/lcm_cnt_rst_gen.sv | 35 +++
 rtl/lcm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lcm_pkg.sv
// Shared constants, handshake state encoding and word-access helpers for the
// local configuration manager.
package lcm_pkg;

    localparam int TUPLE_W = 104;
    localparam int PKT_W   = 32;
    localparam int BYTE_W  = 40;
    localparam int WORD_W  = 32;

    localparam logic [7:0] ADDR_TUP0  = 8'h00;
    localparam logic [7:0] ADDR_TUP3  = 8'h03;
    localparam logic [7:0] ADDR_MSK0  = 8'h04;
    localparam logic [7:0] ADDR_MSK3  = 8'h07;
    localparam logic [7:0] ADDR_CTRL  = 8'h08;
    localparam logic [7:0] ADDR_PKT   = 8'h09;
    localparam logic [7:0] ADDR_BLO   = 8'h0A;
    localparam logic [7:0] ADDR_BHI   = 8'h0B;
    localparam logic [7:0] ADDR_VER   = 8'h0C;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_CLEAR  = 1;

    localparam int SRC_IP_LSB   = 72;
    localparam int DST_IP_LSB   = 40;
    localparam int PROTO_LSB    = 32;
    localparam int SRC_PORT_LSB = 16;
    localparam int DST_PORT_LSB = 0;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_ACK      = 2'd1,
        HS_WAIT_REL = 2'd2
    } hs_state_e;

    // Word 3 only carries the top 8 bits of the 104-bit rule; the rest reads 0.
    function automatic logic [WORD_W-1:0] word_sel(input logic [TUPLE_W-1:0] v,
                                                   input logic [1:0] idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = v[31:0];
            2'd1:    w = v[63:32];
            2'd2:    w = v[95:64];
            default: w = {24'b0, v[103:96]};
        endcase
        return w;
    endfunction

    function automatic logic [TUPLE_W-1:0] word_put(input logic [TUPLE_W-1:0] v,
                                                    input logic [1:0] idx,
                                                    input logic [WORD_W-1:0] wd);
        logic [TUPLE_W-1:0] r;
        r = v;
        case (idx)
            2'd0:    r[31:0]   = wd;
            2'd1:    r[63:32]  = wd;
            2'd2:    r[95:64]  = wd;
            default: r[103:96] = wd[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lcm_cnt_rst_gen.sv
// Pulse stretcher: a load restarts a down-counter, output is high while the
// counter is non-zero, so reloading mid-pulse extends it without a gap.
module cnt_rst_gen #(
    parameter int CNT_RST_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic cnt_rst
);

    localparam int CW = $clog2(CNT_RST_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(CNT_RST_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_rst = (cnt_q != '0);

endmodule

// File: rtl/lcm.sv
// Host register block: stages a 5-tuple rule and mask, commits them atomically
// to the statistics stage, and serves tear-free 40-bit byte counter reads.
module lcm
    import lcm_pkg::*;
#(
    parameter int          CNT_RST_CYCLES = 8,
    parameter logic [31:0] VERSION        = 32'h0001_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cpu_req,
    input  logic           cpu_wr,
    input  logic [7:0]     cpu_addr,
    input  logic [31:0]    cpu_wdata,
    output logic           cpu_ack,
    output logic [31:0]    cpu_rdata,
    input  logic [31:0]    fsm_pkt_num,
    input  logic [39:0]    fsm_byte_num,
    output logic [103:0]   lcm2fsm_5tuple,
    output logic [103:0]   lcm2fsm_5tuplemask,
    output logic           cnt_rst
);

    hs_state_e            state_q, state_d;
    logic [TUPLE_W-1:0]   tup_sh_q, tup_sh_d;
    logic [TUPLE_W-1:0]   msk_sh_q, msk_sh_d;
    logic [TUPLE_W-1:0]   tup_q, tup_d;
    logic [TUPLE_W-1:0]   msk_q, msk_d;
    logic [7:0]           snap_q, snap_d;
    logic [WORD_W-1:0]    rdata_q, rdata_d;
    logic                 access;
    logic                 clr_load;
    logic                 is_tup;
    logic                 is_msk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HS_IDLE:     if (cpu_req) state_d = HS_ACK;
            HS_ACK:      state_d = HS_WAIT_REL;
            HS_WAIT_REL: if (!cpu_req) state_d = HS_IDLE;
            default:     state_d = HS_IDLE;
        endcase
    end

    always_comb begin
        cpu_ack = (state_q == HS_ACK);
        access  = (state_q == HS_IDLE) && cpu_req;
    end

    assign is_tup = (cpu_addr <= ADDR_TUP3);
    assign is_msk = (cpu_addr >= ADDR_MSK0) && (cpu_addr <= ADDR_MSK3);

    // Register file: the access happens on the IDLE->ACK edge; read data is
    // held only for the ack cycle.
    always_comb begin
        tup_sh_d = tup_sh_q;
        msk_sh_d = msk_sh_q;
        tup_d    = tup_q;
        msk_d    = msk_q;
        snap_d   = snap_q;
        rdata_d  = '0;
        clr_load = 1'b0;
        if (access) begin
            if (cpu_wr) begin
                if (is_tup) begin
                    tup_sh_d = word_put(tup_sh_q, cpu_addr[1:0], cpu_wdata);
                end else if (is_msk) begin
                    msk_sh_d = word_put(msk_sh_q, cpu_addr[1:0], cpu_wdata);
                end else if (cpu_addr == ADDR_CTRL) begin
                    if (cpu_wdata[CTRL_COMMIT]) begin
                        tup_d = tup_sh_q;
                        msk_d = msk_sh_q;
                    end
                    clr_load = cpu_wdata[CTRL_CLEAR];
                end
            end else begin
                if (is_tup) begin
                    rdata_d = word_sel(tup_sh_q, cpu_addr[1:0]);
                end else if (is_msk) begin
                    rdata_d = word_sel(msk_sh_q, cpu_addr[1:0]);
                end else if (cpu_addr == ADDR_PKT) begin
                    rdata_d = fsm_pkt_num;
                end else if (cpu_addr == ADDR_BLO) begin
                    rdata_d = fsm_byte_num[31:0];
                    snap_d  = fsm_byte_num[BYTE_W-1:32];
                end else if (cpu_addr == ADDR_BHI) begin
                    rdata_d = {24'b0, snap_q};
                end else if (cpu_addr == ADDR_VER) begin
                    rdata_d = VERSION;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tup_sh_q <= '0;
            msk_sh_q <= '0;
            tup_q    <= '0;
            msk_q    <= '0;
            snap_q   <= '0;
            rdata_q  <= '0;
        end else begin
            tup_sh_q <= tup_sh_d;
            msk_sh_q <= msk_sh_d;
            tup_q    <= tup_d;
            msk_q    <= msk_d;
            snap_q   <= snap_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cpu_rdata          = rdata_q;
    assign lcm2fsm_5tuple     = tup_q;
    assign lcm2fsm_5tuplemask = msk_q;

    cnt_rst_gen #(
        .CNT_RST_CYCLES(CNT_RST_CYCLES)
    ) u_cnt_rst_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (clr_load),
        .cnt_rst (cnt_rst)
    );

endmodule
